// File: rtl/lpc_io_mailbox_if.sv
// lpc_io_mailbox_if: Wishbone slave bus bundle for the LPC I/O mailbox
interface lpc_io_mailbox_if;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC;
  logic [3:0]  WBs_BYTE_STB;
  logic        WBs_WE;
  logic        WBs_STB;
  logic [31:0] WBs_WR_DAT;
  logic [31:0] WBs_RD_DAT;
  logic        WBs_ACK;
  modport master (output WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_STB, WBs_WR_DAT, input WBs_RD_DAT, WBs_ACK);
  modport slave  (input WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_STB, WBs_WR_DAT, output WBs_RD_DAT, WBs_ACK);
endinterface

// File: rtl/lpc_io_mailbox.sv
// lpc_io_mailbox: per-channel LPC I/O-write FIFOs drained over Wishbone; LPC_MBOX_WATERMARK_EN adds a CTRL[15:8] IRQ watermark
module lpc_io_mailbox #(
  parameter int          NUM_CH     = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] RST_BASE   = 16'h0080
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  lpc_io_mailbox_if.slave   wb,
  input  logic              lpc_ev_valid,
  input  logic [15:0]       lpc_ev_addr,
  input  logic [7:0]        lpc_ev_data,
  output logic              lpc_ev_hit,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [NUM_CH-1:0] en_q, en_d, ien_q, ien_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [NUM_CH-1:0] wr_c, rd_c, pop, flush, full, empty, want, push, lvl;
  logic [15:0] base_q [NUM_CH];
  logic [15:0] base_d [NUM_CH];
  logic [PW-1:0] wp_q [NUM_CH];
  logic [PW-1:0] wp_d [NUM_CH];
  logic [PW-1:0] rp_q [NUM_CH];
  logic [PW-1:0] rp_d [NUM_CH];
  logic [CW-1:0] cnt_q [NUM_CH];
  logic [CW-1:0] cnt_d [NUM_CH];
  logic [7:0] wm_rd [NUM_CH];
  logic [23:0] mem_q [NUM_CH][FIFO_DEPTH];
`ifdef LPC_MBOX_WATERMARK_EN
  logic [7:0] wm_q [NUM_CH];
  logic [7:0] wm_d [NUM_CH];
`endif
  logic ack_q, ack_d, hit_q, hit_d, any_q, any_d, acc, found, unused_ok;
  logic [31:0] rd_q, rd_d;
  logic [2:0] ch, sel;
  logic [1:0] rg;
  assign acc = wb.WBs_CYC & wb.WBs_STB & ~ack_q;
  assign ch = wb.WBs_ADR[6:4];
  assign rg = wb.WBs_ADR[3:2];
  assign unused_ok = ^{wb.WBs_ADR, wb.WBs_WR_DAT, wb.WBs_BYTE_STB};
  // descending scan so the lowest matching channel is the one left selected
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (lpc_ev_valid && en_q[i] && base_q[i] == lpc_ev_addr) begin
        found = 1'b1;
        sel = 3'(i);
      end
  end
  always_comb begin
    en_d = en_q;
    ien_d = ien_q;
    ovf_d = ovf_q;
    base_d = base_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
`ifdef LPC_MBOX_WATERMARK_EN
    wm_d = wm_q;
`endif
    {wr_c, rd_c, pop, flush, full, empty, want, push, lvl, irq_d} = '0;
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_c[i] = acc & wb.WBs_WE & (ch == 3'(i));
      rd_c[i] = acc & ~wb.WBs_WE & (ch == 3'(i));
      empty[i] = cnt_q[i] == '0;
      full[i] = cnt_q[i] == CW'(FIFO_DEPTH);
      pop[i] = rd_c[i] & (rg == 2'd3) & ~empty[i];
      flush[i] = wr_c[i] & (rg == 2'd0) & wb.WBs_BYTE_STB[0] & wb.WBs_WR_DAT[2];
      want[i] = found & (sel == 3'(i)) & ~flush[i];
      push[i] = want[i] & (~full[i] | pop[i]);
`ifdef LPC_MBOX_WATERMARK_EN
      wm_rd[i] = wm_q[i];
      lvl[i] = (32'(cnt_q[i]) >= 32'(wm_q[i])) && (wm_q[i] != '0);
      if (wr_c[i] && rg == 2'd0 && wb.WBs_BYTE_STB[1]) wm_d[i] = wb.WBs_WR_DAT[15:8];
`else
      wm_rd[i] = '0;
      lvl[i] = ~empty[i];
`endif
      irq_d[i] = en_q[i] & ien_q[i] & (lvl[i] | ovf_q[i]);
      if (wr_c[i] && rg == 2'd0 && wb.WBs_BYTE_STB[0]) {ien_d[i], en_d[i]} = wb.WBs_WR_DAT[1:0];
      if (wr_c[i] && rg == 2'd1 && wb.WBs_BYTE_STB[0]) base_d[i][7:0] = wb.WBs_WR_DAT[7:0];
      if (wr_c[i] && rg == 2'd1 && wb.WBs_BYTE_STB[1]) base_d[i][15:8] = wb.WBs_WR_DAT[15:8];
      if (wr_c[i] && rg == 2'd2 && wb.WBs_BYTE_STB[1] && wb.WBs_WR_DAT[10]) ovf_d[i] = 1'b0;
      if (want[i] && full[i] && !pop[i]) ovf_d[i] = 1'b1;
      wp_d[i] = flush[i] ? '0 : wp_q[i] + PW'(push[i]);
      rp_d[i] = flush[i] ? '0 : rp_q[i] + PW'(pop[i]);
      cnt_d[i] = flush[i] ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (rd_c[i])
        rd_d = rg == 2'd0 ? {16'b0, wm_rd[i], 6'b0, ien_q[i], en_q[i]} :
               rg == 2'd1 ? {16'b0, base_q[i]} :
               rg == 2'd2 ? {21'b0, ovf_q[i], full[i], empty[i], 8'(cnt_q[i])} :
               empty[i]   ? 32'h8000_0000 : {8'b0, mem_q[i][rp_q[i]]};
    end
    ack_d = acc;
    hit_d = |push;
    any_d = |irq_d;
  end
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      en_q <= '0;
      ien_q <= '0;
      ovf_q <= '0;
      irq_q <= '0;
      base_q <= '{default: RST_BASE};
      wp_q <= '{default: '0};
      rp_q <= '{default: '0};
      cnt_q <= '{default: '0};
`ifdef LPC_MBOX_WATERMARK_EN
      wm_q <= '{default: 8'd1};
`endif
      ack_q <= 1'b0;
      hit_q <= 1'b0;
      any_q <= 1'b0;
      rd_q <= '0;
    end else begin
      en_q <= en_d;
      ien_q <= ien_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      base_q <= base_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
`ifdef LPC_MBOX_WATERMARK_EN
      wm_q <= wm_d;
`endif
      ack_q <= ack_d;
      hit_q <= hit_d;
      any_q <= any_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge WB_CLK)
    for (int i = 0; i < NUM_CH; i++)
      if (!WB_RST && push[i]) mem_q[i][wp_q[i]] <= {lpc_ev_addr, lpc_ev_data};
  assign wb.WBs_ACK = ack_q;
  assign wb.WBs_RD_DAT = rd_q;
  assign lpc_ev_hit = hit_q;
  assign irq_o = irq_q;
  assign irq_any = any_q;
endmodule
